// File: rtl/trap_unit.sv
// ============================================================================
// trap_unit : user-mode trap CSRs, exception/interrupt arbitration and
//             trap-entry/return redirect sequencing at the commit point.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module trap_unit #(
  parameter int              XLEN       = 32,
  parameter int              NUM_EXC    = 16,
  parameter int              NUM_IRQ    = 4,
  parameter logic [XLEN-1:0] RESET_TVEC = 32'h0040_0000
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic               iExValid,
  input  logic [NUM_EXC-1:0] iExVec,
  input  logic [XLEN-1:0]    iPC,
  input  logic [XLEN-1:0]    iInstr,
  input  logic [XLEN-1:0]    iBadAddr,
  input  logic               iUret,
  input  logic [NUM_IRQ-1:0] iIrq,
  input  logic               iCsrWe,
  input  logic [11:0]        iCsrAddr,
  input  logic [XLEN-1:0]    iCsrWData,
  output logic [XLEN-1:0]    oCsrRData,
  output logic               oTrapStall,
  output logic               oRedirect,
  output logic [XLEN-1:0]    oRedirectPC,
  output logic               oInHandler
);

  localparam logic [11:0] c_ADDR_USTATUS = 12'h000;
  localparam logic [11:0] c_ADDR_UIE     = 12'h004;
  localparam logic [11:0] c_ADDR_UTVEC   = 12'h005;
  localparam logic [11:0] c_ADDR_UEPC    = 12'h041;
  localparam logic [11:0] c_ADDR_UCAUSE  = 12'h042;
  localparam logic [11:0] c_ADDR_UTVAL   = 12'h043;
  localparam logic [11:0] c_ADDR_UIP     = 12'h044;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_HANDLER = 1'b1
  } state_e;

  state_e               state_q, state_d;
  logic                 status_uie_q, status_uie_d;
  logic                 status_upie_q, status_upie_d;
  logic [NUM_IRQ-1:0]   uie_q, uie_d;
  logic [XLEN-1:0]      utvec_q, utvec_d;
  logic [XLEN-1:0]      uepc_q, uepc_d;
  logic [XLEN-1:0]      ucause_q, ucause_d;
  logic [XLEN-1:0]      utval_q, utval_d;
  logic                 usip_q, usip_d;
  logic [NUM_IRQ-1:0]   irq_q;
  logic                 redirect_q, redirect_d;
  logic [XLEN-1:0]      redirect_pc_q, redirect_pc_d;

  logic [XLEN-1:0]      w_ustatus;
  logic [XLEN-1:0]      w_uie;
  logic [XLEN-1:0]      w_uip;
  logic [NUM_IRQ-1:0]   w_irq_act;
  logic [XLEN-2:0]      w_exc_code;
  logic [XLEN-1:0]      w_exc_tval;
  logic [XLEN-2:0]      w_irq_code;
  logic                 w_exc_pend;
  logic                 w_irq_pend;
  logic                 w_trap;
  logic                 w_uret;
  logic [XLEN-1:0]      w_cause;
  logic [XLEN-1:0]      w_tval;
  logic [XLEN-1:0]      w_base;
  logic [XLEN-1:0]      w_target;

  // Architectural views of the packed status/enable/pending state.
  always_comb begin
    w_ustatus                 = '0;
    w_ustatus[0]              = status_uie_q;
    w_ustatus[4]              = status_upie_q;
    w_uie                     = '0;
    w_uie[NUM_IRQ-1:0]        = uie_q;
    w_uip                     = '0;
    w_uip[NUM_IRQ-1:0]        = irq_q;
    w_uip[0]                  = irq_q[0] | usip_q;
  end

  assign w_irq_act = uie_q & w_uip[NUM_IRQ-1:0];

  // Descending scan so the lowest set index is the last, winning assignment.
  always_comb begin
    w_exc_code = '0;
    w_exc_tval = '0;
    for (int i = NUM_EXC - 1; i >= 0; i--) begin
      if (iExVec[i]) begin
        w_exc_code = (XLEN-1)'(i);
        case (i)
          0, 1:          w_exc_tval = iPC;
          2:             w_exc_tval = iInstr;
          4, 5, 6, 7:    w_exc_tval = iBadAddr;
          default:       w_exc_tval = '0;
        endcase
      end
    end
  end

  always_comb begin
    w_irq_code = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (w_irq_act[k]) begin
        w_irq_code = (XLEN-1)'(k);
      end
    end
  end

  assign w_exc_pend = iExValid & (|iExVec);
  assign w_irq_pend = (state_q == ST_IDLE) & iExValid & status_uie_q & (|w_irq_act);
  assign w_trap     = w_exc_pend | w_irq_pend;
  assign w_uret     = iExValid & iUret & ~w_trap;
  assign oTrapStall = w_trap | w_uret;

  assign w_cause = w_exc_pend ? {1'b0, w_exc_code} : {1'b1, w_irq_code};
  assign w_tval  = w_exc_pend ? w_exc_tval : '0;
  assign w_base  = {utvec_q[XLEN-1:2], 2'b00};

  always_comb begin
    w_target = uepc_q;
    if (w_trap) begin
      if (!w_exc_pend && (utvec_q[1:0] == 2'b01)) begin
        w_target = w_base + {w_irq_code[XLEN-3:0], 2'b00};
      end else begin
        w_target = w_base;
      end
    end
  end

  always_comb begin
    oCsrRData = '0;
    case (iCsrAddr)
      c_ADDR_USTATUS: oCsrRData = w_ustatus;
      c_ADDR_UIE:     oCsrRData = w_uie;
      c_ADDR_UTVEC:   oCsrRData = utvec_q;
      c_ADDR_UEPC:    oCsrRData = uepc_q;
      c_ADDR_UCAUSE:  oCsrRData = ucause_q;
      c_ADDR_UTVAL:   oCsrRData = utval_q;
      c_ADDR_UIP:     oCsrRData = w_uip;
      default:        oCsrRData = '0;
    endcase
  end

  // Software writes are applied first; trap/uret updates below override them.
  always_comb begin
    state_d       = state_q;
    status_uie_d  = status_uie_q;
    status_upie_d = status_upie_q;
    uie_d         = uie_q;
    utvec_d       = utvec_q;
    uepc_d        = uepc_q;
    ucause_d      = ucause_q;
    utval_d       = utval_q;
    usip_d        = usip_q;
    redirect_d    = w_trap | w_uret;
    redirect_pc_d = (w_trap | w_uret) ? w_target : redirect_pc_q;

    if (iCsrWe) begin
      case (iCsrAddr)
        c_ADDR_USTATUS: begin
          status_uie_d  = iCsrWData[0];
          status_upie_d = iCsrWData[4];
        end
        c_ADDR_UIE:    uie_d    = iCsrWData[NUM_IRQ-1:0];
        c_ADDR_UTVEC:  utvec_d  = iCsrWData;
        c_ADDR_UEPC:   uepc_d   = iCsrWData;
        c_ADDR_UCAUSE: ucause_d = iCsrWData;
        c_ADDR_UTVAL:  utval_d  = iCsrWData;
        c_ADDR_UIP:    usip_d   = iCsrWData[0];
        default: ;
      endcase
    end

    if (w_trap) begin
      uepc_d        = iPC;
      ucause_d      = w_cause;
      utval_d       = w_tval;
      status_upie_d = (state_q == ST_IDLE) ? status_uie_q : status_upie_q;
      status_uie_d  = 1'b0;
      state_d       = ST_HANDLER;
    end else if (w_uret) begin
      status_uie_d  = status_upie_q;
      status_upie_d = 1'b1;
      state_d       = ST_IDLE;
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q       <= ST_IDLE;
      status_uie_q  <= 1'b0;
      status_upie_q <= 1'b0;
      uie_q         <= '0;
      utvec_q       <= RESET_TVEC;
      uepc_q        <= '0;
      ucause_q      <= '0;
      utval_q       <= '0;
      usip_q        <= 1'b0;
      irq_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      status_uie_q  <= status_uie_d;
      status_upie_q <= status_upie_d;
      uie_q         <= uie_d;
      utvec_q       <= utvec_d;
      uepc_q        <= uepc_d;
      ucause_q      <= ucause_d;
      utval_q       <= utval_d;
      usip_q        <= usip_d;
      irq_q         <= iIrq;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  assign oRedirect   = redirect_q;
  assign oRedirectPC = redirect_pc_q;
  assign oInHandler  = (state_q == ST_HANDLER);

endmodule

`default_nettype wire

// File: tb/tb_trap_unit.sv
// ============================================================================
// tb_trap_unit : directed vector table plus an async-reset sequence for trap_unit.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module tb_trap_unit;

  localparam logic [11:0] A_US   = 12'h000;
  localparam logic [11:0] A_UIE  = 12'h004;
  localparam logic [11:0] A_TV   = 12'h005;
  localparam logic [11:0] A_EPC  = 12'h041;
  localparam logic [11:0] A_CA   = 12'h042;
  localparam logic [11:0] A_TVAL = 12'h043;
  localparam logic [11:0] A_UIP  = 12'h044;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ex_vec;
  logic [31:0] pc, instr, bad;
  logic        uret;
  logic [3:0]  irq;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        trap_stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        in_handler;

  int checks = 0;
  int errors = 0;

  trap_unit #(
    .XLEN(32), .NUM_EXC(16), .NUM_IRQ(4), .RESET_TVEC(32'h0040_0000)
  ) dut (
    .iCLK(clk), .iRST_N(rst_n), .iExValid(ex_valid), .iExVec(ex_vec),
    .iPC(pc), .iInstr(instr), .iBadAddr(bad), .iUret(uret), .iIrq(irq),
    .iCsrWe(csr_we), .iCsrAddr(csr_addr), .iCsrWData(csr_wdata),
    .oCsrRData(csr_rdata), .oTrapStall(trap_stall), .oRedirect(redirect),
    .oRedirectPC(redirect_pc), .oInHandler(in_handler)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] exvec;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] bad;
    logic        uret;
    logic [3:0]  irq;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        e_stall;
    logic [31:0] e_rdata;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_inh;
  } vec_t;

  vec_t tv[$];

  task automatic add(input logic v, input logic [15:0] ev, input logic [31:0] p,
                     input logic [31:0] ins, input logic [31:0] b, input logic u,
                     input logic [3:0] iq, input logic w, input logic [11:0] a,
                     input logic [31:0] wd, input logic es, input logic [31:0] er,
                     input logic ed, input logic [31:0] ep, input logic eh);
    vec_t t;
    t.valid = v;  t.exvec = ev; t.pc = p; t.instr = ins; t.bad = b; t.uret = u;
    t.irq = iq;   t.we = w;     t.addr = a; t.wdata = wd;
    t.e_stall = es; t.e_rdata = er; t.e_redir = ed; t.e_rpc = ep; t.e_inh = eh;
    tv.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    ex_valid = 1'b0; ex_vec = '0; pc = '0; instr = '0; bad = '0; uret = 1'b0;
    irq = '0; csr_we = 1'b0; csr_addr = '0; csr_wdata = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    drive_idle();

    //  v  exvec     pc            instr         bad           u  irq we addr   wdata        | stall rdata        redir rpc          inh
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_US,   32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_UIE,  32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TV,   32'h0,         0, 32'h0040_0000,0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_EPC,  32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_CA,   32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TVAL, 32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_UIP,  32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, 12'h123,32'h0,         0, 32'h0,        0, 32'h0,        0);
    // illegal instr + load fault together: cause 2 wins
    add(1, 16'h0014, 32'h0040_0010,32'hFFFF_FFFF,32'hDEAD_0000,0, 0, 0, A_CA,   32'h0,         1, 32'h0,        1, 32'h0040_0000,1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_CA,   32'h0,         0, 32'h2,        0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TVAL, 32'h0,         0, 32'hFFFF_FFFF,0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_EPC,  32'h0,         0, 32'h0040_0010,0, 32'h0,        1);
    add(1, 16'h0000, 32'h0040_0014,32'h0,        32'h0,        1, 0, 0, A_US,   32'h0,         1, 32'h0,        1, 32'h0040_0010,0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_US,   32'h0,         0, 32'h10,       0, 32'h0,        0);
    // vectored utvec, enable irq1, set UIE
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 1, A_TV,   32'h0040_0101, 0, 32'h0040_0000,0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 1, A_UIE,  32'h2,         0, 32'h0,        0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 1, A_US,   32'h1,         0, 32'h10,       0, 32'h0,        0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 2, 0, A_UIP,  32'h0,         0, 32'h0,        0, 32'h0,        0);
    add(1, 16'h0000, 32'h0040_0020,32'h0,        32'h0,        0, 2, 0, A_UIP,  32'h0,         1, 32'h2,        1, 32'h0040_0104,1);
    add(1, 16'h0000, 32'h0040_0024,32'h0,        32'h0,        0, 2, 0, A_CA,   32'h0,         0, 32'h8000_0001,0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 2, 0, A_US,   32'h0,         0, 32'h10,       0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 2, 0, A_EPC,  32'h0,         0, 32'h0040_0020,0, 32'h0,        1);
    add(1, 16'h0000, 32'h0040_0030,32'h0,        32'h0,        1, 2, 0, A_US,   32'h0,         1, 32'h10,       1, 32'h0040_0020,0);
    add(1, 16'h0000, 32'h0040_0040,32'h0,        32'h0,        0, 2, 0, A_US,   32'h0,         1, 32'h11,       1, 32'h0040_0104,1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_EPC,  32'h0,         0, 32'h0040_0040,0, 32'h0,        1);
    // nested exception inside the handler keeps UPIE
    add(1, 16'h0001, 32'h0040_0050,32'h0,        32'h0,        0, 0, 0, A_CA,   32'h0,         1, 32'h8000_0001,1, 32'h0040_0100,1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TVAL, 32'h0,         0, 32'h0040_0050,0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_US,   32'h0,         0, 32'h10,       0, 32'h0,        1);
    add(1, 16'h0000, 32'h0040_0054,32'h0,        32'h0,        1, 0, 0, A_CA,   32'h0,         1, 32'h0,        1, 32'h0040_0050,0);
    // back-to-back accepts: load fault then uret
    add(1, 16'h0020, 32'h0040_0060,32'h0,        32'h2000_0004,0, 0, 0, A_US,   32'h0,         1, 32'h11,       1, 32'h0040_0100,1);
    add(1, 16'h0000, 32'h0040_0064,32'h0,        32'h0,        1, 0, 0, A_TVAL, 32'h0,         1, 32'h2000_0004,1, 32'h0040_0060,0);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_US,   32'h0,         0, 32'h11,       0, 32'h0,        0);
    // store misaligned + irq0 + uepc write in the same cycle
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 1, 1, A_UIE,  32'h3,         0, 32'h2,        0, 32'h0,        0);
    add(1, 16'h0040, 32'h0040_0070,32'h0,        32'h1001_0002,0, 1, 1, A_EPC,  32'h1234,      1, 32'h0040_0060,1, 32'h0040_0100,1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_EPC,  32'h0,         0, 32'h0040_0070,0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_CA,   32'h0,         0, 32'h6,        0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TVAL, 32'h0,         0, 32'h1001_0002,0, 32'h0,        1);
    add(1, 16'h0008, 32'h0040_0080,32'h0,        32'h5555_5555,0, 0, 0, A_CA,   32'h0,         1, 32'h6,        1, 32'h0040_0100,1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TVAL, 32'h0,         0, 32'h0,        0, 32'h0,        1);
    add(0, 16'hFFFF, 32'h0,        32'h0,        32'h0,        1, 0, 0, A_CA,   32'h0,         0, 32'h3,        0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 1, A_UIP,  32'hF,         0, 32'h0,        0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_UIP,  32'h0,         0, 32'h1,        0, 32'h0,        1);
    // exception beats uret in the same commit
    add(1, 16'h0002, 32'h0040_0090,32'h0,        32'h0,        1, 0, 0, A_CA,   32'h0,         1, 32'h3,        1, 32'h0040_0100,1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_CA,   32'h0,         0, 32'h1,        0, 32'h0,        1);
    add(0, 16'h0000, 32'h0,        32'h0,        32'h0,        0, 0, 0, A_TVAL, 32'h0,         0, 32'h0040_0090,0, 32'h0,        1);

    repeat (2) @(posedge clk);
    #1;
    chk("reset oRedirect",    {31'h0, redirect},   32'h0);
    chk("reset oRedirectPC",  redirect_pc,         32'h0);
    chk("reset oInHandler",   {31'h0, in_handler}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      ex_valid = tv[i].valid; ex_vec = tv[i].exvec; pc = tv[i].pc;
      instr = tv[i].instr; bad = tv[i].bad; uret = tv[i].uret; irq = tv[i].irq;
      csr_we = tv[i].we; csr_addr = tv[i].addr; csr_wdata = tv[i].wdata;
      #1;
      chk($sformatf("v%0d stall", i), {31'h0, trap_stall}, {31'h0, tv[i].e_stall});
      chk($sformatf("v%0d rdata", i), csr_rdata, tv[i].e_rdata);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d redirect", i), {31'h0, redirect}, {31'h0, tv[i].e_redir});
      chk($sformatf("v%0d in_handler", i), {31'h0, in_handler}, {31'h0, tv[i].e_inh});
      if (tv[i].e_redir) chk($sformatf("v%0d redirect_pc", i), redirect_pc, tv[i].e_rpc);
    end

    // Reset asserted while a trap is being accepted: its redirect must vanish.
    @(negedge clk);
    drive_idle();
    ex_valid = 1'b1; ex_vec = 16'h0001; pc = 32'h0040_00A0;
    #1;
    chk("rst-seq stall", {31'h0, trap_stall}, 32'h1);
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst-seq redirect in reset", {31'h0, redirect}, 32'h0);
    chk("rst-seq redirect_pc in reset", redirect_pc, 32'h0);
    chk("rst-seq in_handler in reset", {31'h0, in_handler}, 32'h0);
    @(negedge clk);
    drive_idle();
    rst_n = 1'b1;
    begin
      logic [11:0] ra [7];
      logic [31:0] rv [7];
      ra = '{A_US, A_UIE, A_TV, A_EPC, A_CA, A_TVAL, A_UIP};
      rv = '{32'h0, 32'h0, 32'h0040_0000, 32'h0, 32'h0, 32'h0, 32'h0};
      for (int j = 0; j < 7; j++) begin
        if (j != 0) @(negedge clk);
        csr_addr = ra[j];
        #1;
        chk($sformatf("rst-seq csr %h", ra[j]), csr_rdata, rv[j]);
        @(posedge clk);
        #1;
        chk($sformatf("rst-seq redirect c%0d", j), {31'h0, redirect}, 32'h0);
        chk($sformatf("rst-seq in_handler c%0d", j), {31'h0, in_handler}, 32'h0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
